// File: rtl/e203_tcm_ram_pipe.sv
// rtl/e203_tcm_ram_pipe.sv - single-port TCM SRAM with request/response handshake, init fill and range check
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake; ready only once the init fill is done
//   req_we          1 = write, 0 = read
//   req_addr        word address (AW bits)
//   req_wem         byte-lane write enables (MW lanes, last lane may be narrower than 8 bits)
//   req_wdata       write data (DW bits)
//   rsp_valid       one pulse per accepted read, 1 or 2 cycles after acceptance (OUT_REG)
//   rsp_rdata       read data, held between responses
//   rsp_err         read address was >= DP (data forced to zero)
//   init_busy       zero-fill sequence in progress
module e203_tcm_ram_pipe #(
    parameter int              DP       = 4096,
    parameter int              AW       = 12,
    parameter int              DW       = 64,
    parameter int              MW       = (DW + 7) / 8,
    parameter int              OUT_REG  = 1,
    parameter int              INIT_EN  = 1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [MW-1:0] req_wem,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          init_busy
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW:0]   DP_LIM   = (AW + 1)'(DP);
    localparam logic [AW-1:0] CNT_LAST = AW'(DP - 1);

    logic [0:0]    state;
    logic [AW-1:0] init_cnt;
    logic [DW-1:0] mem [0:DP-1];

    logic          in_run;
    logic          accept;
    logic          addr_ok;
    logic          wr_en;
    logic          rd_acc;
    logic          init_we;

    // ready is also masked by rst so that an INIT_EN=0 instance (reset
    // state RUN) still reports not-ready while held in reset.
    assign in_run    = (state == ST_RUN);
    assign req_ready = in_run & ~rst;
    assign init_busy = ~in_run;
    assign accept    = req_valid & req_ready;
    assign addr_ok   = ({1'b0, req_addr} < DP_LIM);
    assign wr_en     = accept & req_we & addr_ok;
    assign rd_acc    = accept & ~req_we;
    assign init_we   = (state == ST_INIT) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == CNT_LAST) begin
                state <= ST_RUN;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Array write port, shared by the init sequencer and accepted writes.
    // Out-of-range writes never reach here (addr_ok gates wr_en).
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (wr_en) begin
            for (int b = 0; b < DW; b++) begin
                if (req_wem[b/8]) begin
                    mem[req_addr][b] <= req_wdata[b];
                end
            end
        end
    end

    // Stage 1: registered read address. An out-of-range read keeps a safe
    // in-array address and carries the error flag down the pipe instead.
    logic          p1_valid;
    logic          p1_err;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_err   <= 1'b0;
            p1_addr  <= '0;
        end else begin
            p1_valid <= rd_acc;
            if (rd_acc) begin
                p1_err  <= ~addr_ok;
                p1_addr <= addr_ok ? req_addr : '0;
            end
        end
    end

    assign p1_data = p1_err ? '0 : mem[p1_addr];

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          p2_valid;
            logic          p2_err;
            logic [DW-1:0] p2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p2_valid <= 1'b0;
                    p2_err   <= 1'b0;
                    p2_data  <= '0;
                end else begin
                    p2_valid <= p1_valid;
                    if (p1_valid) begin
                        p2_err  <= p1_err;
                        p2_data <= p1_data;
                    end
                end
            end

            assign rsp_valid = p2_valid;
            assign rsp_err   = p2_valid & p2_err;
            assign rsp_rdata = p2_data;
        end else begin : g_no_out_reg
            // The array output follows p1_addr, which stays put but whose
            // word may be rewritten; hold_q keeps the last delivered value.
            logic [DW-1:0] hold_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q <= '0;
                end else if (p1_valid) begin
                    hold_q <= p1_data;
                end
            end

            assign rsp_valid = p1_valid;
            assign rsp_err   = p1_valid & p1_err;
            assign rsp_rdata = p1_valid ? p1_data : hold_q;
        end
    endgenerate

endmodule

// File: tb/tb_e203_tcm_ram_pipe.sv
// tb/tb_e203_tcm_ram_pipe.sv - self-checking bench for e203_tcm_ram_pipe
module tb_e203_tcm_ram_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // Instance A: DP=16, DW=64, OUT_REG=1, fill 0xA5..
    logic        a_rst, a_req_valid, a_req_ready, a_req_we;
    logic [3:0]  a_req_addr;
    logic [7:0]  a_req_wem;
    logic [63:0] a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err, a_init_busy;

    // Instance B: DP=12, AW=4, DW=36 (MW=5), OUT_REG=0, fill 0
    logic        b_rst, b_req_valid, b_req_ready, b_req_we;
    logic [3:0]  b_req_addr;
    logic [4:0]  b_req_wem;
    logic [35:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err, b_init_busy;

    logic [63:0] ma [16];
    logic [35:0] mb [12];
    logic [63:0] a_last = '0;
    logic [35:0] b_last = '0;

    e203_tcm_ram_pipe #(
        .DP(16), .AW(4), .DW(64), .OUT_REG(1), .INIT_EN(1),
        .INIT_VAL(64'hA5A5_A5A5_A5A5_A5A5)
    ) u_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wem(a_req_wem), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .init_busy(a_init_busy)
    );

    e203_tcm_ram_pipe #(
        .DP(12), .AW(4), .DW(36), .OUT_REG(0), .INIT_EN(1),
        .INIT_VAL(36'h0)
    ) u_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wem(b_req_wem), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .init_busy(b_init_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every response must match the head of the queue,
    // including the cycle it was predicted for; idle cycles must hold data.
    always @(negedge clk) begin
        if (a_rst) begin
            a_last = '0;
        end else if (a_rsp_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rsp", 64'(a_rsp_valid), 64'h0);
            end else begin
                ea = qa.pop_front();
                check("a_rsp_cycle", 64'(cyc), 64'(ea.cyc));
                check("a_rsp_err", 64'(a_rsp_err), 64'(ea.err));
                check("a_rsp_data", a_rsp_rdata, ea.data);
                a_last = ea.data;
            end
        end else begin
            check("a_hold", a_rsp_rdata, a_last);
        end
    end

    always @(negedge clk) begin
        if (b_rst) begin
            b_last = '0;
        end else if (b_rsp_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rsp", 64'(b_rsp_valid), 64'h0);
            end else begin
                eb = qb.pop_front();
                check("b_rsp_cycle", 64'(cyc), 64'(eb.cyc));
                check("b_rsp_err", 64'(b_rsp_err), 64'(eb.err));
                check("b_rsp_data", 64'(b_rsp_rdata), eb.data);
                b_last = eb.data[35:0];
            end
        end else begin
            check("b_hold", 64'(b_rsp_rdata), 64'(b_last));
        end
    end

    // Drive one request; called at posedge+1, returns at the next posedge+1.
    task automatic a_drive(input logic we, input logic [3:0] addr, input logic [7:0] wem, input logic [63:0] wd);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wem   = wem;
        a_req_wdata = wd;
        if (!we) qa.push_back('{cyc + 2, 1'b0, ma[addr]});
        @(posedge clk); #1;
        if (we) for (int b = 0; b < 64; b++) if (wem[b/8]) ma[addr][b] = wd[b];
    endtask

    task automatic a_idle(input int n);
        a_req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic b_drive(input logic we, input logic [3:0] addr, input logic [4:0] wem, input logic [35:0] wd);
        b_req_valid = 1'b1;
        b_req_we    = we;
        b_req_addr  = addr;
        b_req_wem   = wem;
        b_req_wdata = wd;
        if (!we) begin
            if (addr >= 4'd12) qb.push_back('{cyc + 1, 1'b1, 64'h0});
            else               qb.push_back('{cyc + 1, 1'b0, 64'(mb[addr])});
        end
        @(posedge clk); #1;
        if (we && addr < 4'd12) for (int b = 0; b < 36; b++) if (wem[b/8]) mb[addr][b] = wd[b];
    endtask

    task automatic b_idle(input int n);
        b_req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Counts not-ready cycles after reset release (bounded), then realigns.
    task automatic a_wait_init(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_req_ready === 1'b1) break;
            if (a_init_busy !== 1'b1) check("a_busy_during_init", 64'(a_init_busy), 64'h1);
            n++;
        end
        a_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int n_init;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wem = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wem = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_ready", 64'(a_req_ready), 64'h0);
        check("a_rst_valid", 64'(a_rsp_valid), 64'h0);
        check("a_rst_rdata", a_rsp_rdata, 64'h0);
        check("a_rst_err", 64'(a_rsp_err), 64'h0);
        check("a_rst_busy", 64'(a_init_busy), 64'h1);
        check("b_rst_ready", 64'(b_req_ready), 64'h0);
        check("b_rst_busy", 64'(b_init_busy), 64'h1);

        // Init fill with a write held on the port throughout: it must be ignored.
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd2; a_req_wem = 8'hFF; a_req_wdata = 64'h0;
        a_rst = 1'b0; b_rst = 1'b0;
        a_wait_init(n_init);
        check("a_init_cycles", 64'(n_init), 64'd16);
        check("a_busy_after_init", 64'(a_init_busy), 64'h0);
        for (int i = 0; i < 16; i++) ma[i] = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int i = 0; i < 12; i++) mb[i] = 36'h0;

        for (int i = 0; i < 16; i++) a_drive(1'b0, 4'(i), 8'h00, 64'h0);
        a_idle(3);

        // Byte mask
        a_drive(1'b1, 4'd3, 8'hFF, 64'h1122_3344_5566_7788);
        a_drive(1'b1, 4'd3, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF);
        a_drive(1'b0, 4'd3, 8'h00, 64'h0);
        a_idle(3);
        check("a_byte_mask", a_rsp_rdata, 64'h1122_3344_55FF_77FF);

        // Back-to-back reads after distinct writes
        a_drive(1'b1, 4'd1, 8'hFF, 64'h1111_1111_1111_1111);
        a_drive(1'b1, 4'd2, 8'hFF, 64'h2222_2222_2222_2222);
        a_drive(1'b1, 4'd3, 8'hFF, 64'h3333_3333_3333_3333);
        a_drive(1'b0, 4'd1, 8'h00, 64'h0);
        a_drive(1'b0, 4'd2, 8'h00, 64'h0);
        a_drive(1'b0, 4'd3, 8'h00, 64'h0);
        a_idle(4);
        check("a_hold_last", a_rsp_rdata, 64'h3333_3333_3333_3333);
        check("a_idle_valid", 64'(a_rsp_valid), 64'h0);

        // Read-after-write
        a_drive(1'b1, 4'd5, 8'hFF, 64'hCAFE);
        a_drive(1'b0, 4'd5, 8'h00, 64'h0);
        a_idle(3);
        check("a_raw", a_rsp_rdata, 64'hCAFE);

        // Reset at init cycle 7: fill restarts from scratch
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        a_rst = 1'b1;
        #1;
        check("a_midinit_busy", 64'(a_init_busy), 64'h1);
        check("a_midinit_ready", 64'(a_req_ready), 64'h0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_wait_init(n_init);
        check("a_reinit_cycles", 64'(n_init), 64'd16);

        // Reset with a read in flight: the response must vanish
        a_drive(1'b0, 4'd4, 8'h00, 64'h0);
        a_req_valid = 1'b0;
        a_rst = 1'b1;
        qa.delete();
        #1;
        check("a_midread_valid", 64'(a_rsp_valid), 64'h0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a_no_rsp_after_rst", 64'(a_rsp_valid), 64'h0);
        end
        @(posedge clk); #1;

        // Instance B: out of range, odd width, latency 1
        check("b_ready", 64'(b_req_ready), 64'h1);
        b_drive(1'b1, 4'd11, 5'h1F, 36'h123);
        b_drive(1'b1, 4'd13, 5'h1F, 36'hDEAD);
        b_drive(1'b0, 4'd13, 5'h00, 36'h0);
        b_drive(1'b0, 4'd11, 5'h00, 36'h0);
        b_idle(2);
        check("b_oor_prior", 64'(b_rsp_rdata), 64'h123);
        b_drive(1'b1, 4'd4, 5'h1F, 36'h0_AAAA_AAAA);
        b_drive(1'b1, 4'd4, 5'h10, 36'hF_1234_5678);
        b_drive(1'b0, 4'd4, 5'h00, 36'h0);
        b_idle(2);
        check("b_odd_lane", 64'(b_rsp_rdata), 64'hF_AAAA_AAAA);
        b_drive(1'b0, 4'd11, 5'h00, 36'h0);
        b_drive(1'b0, 4'd4, 5'h00, 36'h0);
        b_drive(1'b0, 4'd13, 5'h00, 36'h0);
        b_idle(3);
        check("b_err_last_data", 64'(b_rsp_rdata), 64'h0);

        check("a_queue_drained", 64'(qa.size()), 64'h0);
        check("b_queue_drained", 64'(qb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e203_tcm_ram_pipe.md
Name: e203_tcm_ram_pipe

Overview:
- Parametrised single-port TCM SRAM block, successor to the current ITCM/DTCM RAM wrapper.
- Adds a request/response handshake, an optional output pipeline register, a post-reset init (zero-fill) sequencer, and out-of-range address detection.
- Sits between the TCM controller's SRAM port and the inferred block RAM.
- Used for ITCM (DW=64) and DTCM (DW=32) instances.

Parameters:
- DP, 4096, depth in words.
- AW, 12, address width; legal when 2^AW >= DP.
- DW, 64, data width; any value 8..128.
- MW, (DW+7)/8, byte-write-mask width; the last lane covers the remaining DW-8*(MW-1) bits.
- OUT_REG, 1, 0 = read latency 1, 1 = read latency 2 (extra output flop).
- INIT_EN, 1, 1 = zero-fill the array after reset before accepting requests.
- INIT_VAL, 0, DW-bit fill pattern written during init.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wem  in  MW  byte-lane write enables.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data valid; one pulse per accepted read.
- rsp_rdata  out  DW  read data.
- rsp_err  out  1  qualifies rsp_valid; read address >= DP.
- init_busy  out  1  init sequence in progress.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=INIT_EN, FSM=INIT (INIT_EN=1) or RUN (INIT_EN=0), init counter=0. The array contents are not reset.
- FSM INIT:
  - One word per cycle: mem[cnt] <= INIT_VAL, cnt increments.
  - Exits to RUN in the cycle after cnt==DP-1 is written, so INIT lasts exactly DP cycles after reset deassertion.
  - req_ready=0 and init_busy=1 throughout.
  - Requests presented during INIT are not accepted and have no effect.
- FSM RUN:
  - req_ready=1 every cycle; init_busy=0.
  - A request is accepted when req_valid & req_ready. RUN is terminal until the next reset.
- Write:
  - Byte lane i is updated iff req_wem[i] on the accepting edge.
  - req_wem==0 is a legal no-op.
  - Writes to addr >= DP are dropped silently and return no response.
- Read:
  - The array is read with a registered address.
  - OUT_REG=0: rsp_valid/rsp_rdata appear in the cycle after acceptance.
  - OUT_REG=1: they appear two cycles after acceptance.
  - Fully pipelined: back-to-back reads give back-to-back rsp_valid in order.
- Out-of-range read: addr >= DP gives rsp_valid=1, rsp_err=1, rsp_rdata=0, with the same latency as a normal read.
- Hold: rsp_rdata keeps its last value while rsp_valid=0; it changes only on a new read response.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data. This is inherent to the single port, because the write completes at the accepting edge.
- No response backpressure: the consumer must take rsp_* in the rsp_valid cycle.
- Reset mid-INIT: returns to INIT with cnt=0; the full DP-cycle fill restarts.
- Reset mid-read: in-flight responses are discarded; rsp_valid=0.

Test Plan:
- Init fill: DP=16, INIT_EN=1, INIT_VAL=0xA5A5_A5A5_A5A5_A5A5. Release rst and hold req_valid=1 throughout.
  - req_ready=0 and init_busy=1 for exactly 16 cycles, then req_ready=1.
  - Reads of addr 0..15 all return 0xA5A5A5A5A5A5A5A5.
- Byte mask: write 0x1122334455667788 to addr 3 with wem=0xFF, then write 0xFFFFFFFFFFFFFFFF with wem=0x05, then read addr 3.
  - rsp_rdata=0x11223344_55FF77FF.
- Latency and pipelining: back-to-back reads of addr 1, 2, 3, each holding a distinct value.
  - OUT_REG=0: rsp_valid in cycles +1, +2, +3, data in order.
  - OUT_REG=1: same pattern shifted one cycle later.
  - rsp_rdata holds the addr-3 value afterwards.
- Out of range: DP=12, AW=4; write 0xDEAD to addr 13, then read addr 13.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Read addr 11 returns the unchanged prior value with rsp_err=0.
- Read-after-write: write 0xCAFE to addr 5 in cycle N, read addr 5 in cycle N+1.
  - Returns 0xCAFE.
- Reset mid-operation: assert rst at init cycle 7 and release.
  - Init restarts and runs the full 16 cycles.
  - Assert rst with a read in flight: no rsp_valid after reset.
- Odd width: DW=36, MW=5; write 0xF_12345678 with wem=0x10.
  - Only bits [35:32] change.
